// File: rtl/tester_run_sequencer_if.sv
// Bundle of the command, status and generator-facing signals of the run sequencer.
// The master side is the control/register block together with the generators.
// The slave side is the sequencer itself.
interface tester_run_sequencer_if #(
    parameter int NUM_PORTS = 4,
    parameter int DUR_WIDTH = 32,
    parameter int CNT_WIDTH = 32
);
    logic                           cmd_start;
    logic                           cmd_abort;
    logic [NUM_PORTS-1:0]           cmd_port_mask;
    logic [DUR_WIDTH-1:0]           cmd_duration;
    logic [NUM_PORTS-1:0]           gen_ready;
    logic [NUM_PORTS-1:0]           tx_last_fire;
    logic                           gen_rst;
    logic [NUM_PORTS-1:0]           gen_start;
    logic [NUM_PORTS-1:0]           gen_stop;
    logic                           busy;
    logic                           done;
    logic                           cmd_err;
    logic                           timed_out;
    logic                           aborted;
    logic [DUR_WIDTH-1:0]           elapsed;
    logic [NUM_PORTS*CNT_WIDTH-1:0] frame_count;
    logic [2:0]                     dbg_state;

    modport master (
        output cmd_start, cmd_abort, cmd_port_mask, cmd_duration, gen_ready, tx_last_fire,
        input  gen_rst, gen_start, gen_stop, busy, done, cmd_err, timed_out, aborted,
               elapsed, frame_count, dbg_state
    );

    modport slave (
        input  cmd_start, cmd_abort, cmd_port_mask, cmd_duration, gen_ready, tx_last_fire,
        output gen_rst, gen_start, gen_stop, busy, done, cmd_err, timed_out, aborted,
               elapsed, frame_count, dbg_state
    );
endinterface

// File: rtl/tester_run_sequencer.sv
// Sequences one timed test run across NUM_PORTS frame generators and counts frames per port.
//
// Handshake: cmd_start is a request qualified by busy. It is taken only while busy is low,
// and the mask and duration are captured on that same cycle. A request that arrives while
// busy is high is dropped, not queued. gen_start and gen_stop are one-cycle pulses with no
// back-pressure. gen_ready acts as a per-port level that the sequencer polls.
module tester_run_sequencer #(
    parameter int NUM_PORTS      = 4,
    parameter int DUR_WIDTH      = 32,
    parameter int CNT_WIDTH      = 32,
    parameter int GEN_RST_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                    clk,
    input logic                    rst,
    tester_run_sequencer_if.slave  bus
);
    localparam int RST_W = $clog2(GEN_RST_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RST_W-1:0]     RST_LAST = RST_W'(GEN_RST_CYCLES - 1);
    localparam logic [RST_W-1:0]     RST_ONE  = RST_W'(1);
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]     TMO_ONE  = TMO_W'(1);
    localparam logic [DUR_WIDTH-1:0] DUR_ONE  = DUR_WIDTH'(1);
    localparam logic [DUR_WIDTH-1:0] DUR_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_GEN_RST, S_WAIT_RDY, S_START, S_RUN, S_STOP, S_DRAIN, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 abort_set, timeout_set;
    logic [NUM_PORTS-1:0] mask_q;
    logic [DUR_WIDTH-1:0] dur_q, run_cnt_q, elapsed_q;
    logic [RST_W-1:0]     rst_cnt_q;
    logic [TMO_W-1:0]     tmo_cnt_q;
    logic [CNT_WIDTH-1:0] frame_cnt_q [NUM_PORTS];
    logic                 timed_out_q, aborted_q, cmd_err_q;
    logic                 all_rdy, accept, counting;

    // A port that is masked out never holds up the run.
    assign all_rdy  = &(bus.gen_ready | ~mask_q);
    assign accept   = (state_q == S_IDLE) && bus.cmd_start && (bus.cmd_port_mask != '0);
    assign counting = (state_q == S_START) || (state_q == S_RUN) ||
                      (state_q == S_STOP)  || (state_q == S_DRAIN);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic, plus the abort and timeout events that are recorded in the status bits.
    always_comb begin
        state_d     = state_q;
        abort_set   = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            S_IDLE:     if (accept) state_d = S_GEN_RST;
            S_GEN_RST: begin
                if (bus.cmd_abort) begin
                    state_d   = S_DONE;
                    abort_set = 1'b1;
                end else if (rst_cnt_q == RST_LAST) begin
                    state_d = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (bus.cmd_abort) begin
                    state_d   = S_DONE;
                    abort_set = 1'b1;
                end else if (all_rdy) begin
                    state_d = S_START;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = S_DONE;
                    timeout_set = 1'b1;
                end
            end
            S_START:    state_d = S_RUN;
            S_RUN: begin
                // When abort and expiry coincide, the run is reported as aborted.
                if (bus.cmd_abort) begin
                    state_d   = S_STOP;
                    abort_set = 1'b1;
                end else if (run_cnt_q == (dur_q - DUR_ONE)) begin
                    state_d = S_STOP;
                end
            end
            S_STOP:     state_d = S_DRAIN;
            S_DRAIN: begin
                // On the first DRAIN cycle, ready still reflects the state before the stop
                // pulse, so the check is skipped for that cycle.
                if ((tmo_cnt_q != '0) && all_rdy) begin
                    state_d = S_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = S_DONE;
                    timeout_set = 1'b1;
                end
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Run parameters, phase counters, status bits and per-port frame counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q      <= '0;
            dur_q       <= DUR_ONE;
            run_cnt_q   <= '0;
            elapsed_q   <= '0;
            rst_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            timed_out_q <= 1'b0;
            aborted_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) frame_cnt_q[i] <= '0;
        end else begin
            cmd_err_q <= (state_q == S_IDLE) && bus.cmd_start && (bus.cmd_port_mask == '0);
            rst_cnt_q <= (state_q == S_GEN_RST) ? rst_cnt_q + RST_ONE : '0;
            run_cnt_q <= (state_q == S_RUN && state_d == S_RUN) ? run_cnt_q + DUR_ONE : '0;
            tmo_cnt_q <= ((state_q == S_WAIT_RDY || state_q == S_DRAIN) && state_d == state_q)
                         ? tmo_cnt_q + TMO_ONE : '0;
            if (timeout_set) timed_out_q <= 1'b1;
            if (abort_set)   aborted_q   <= 1'b1;
            if (accept) begin
                mask_q      <= bus.cmd_port_mask;
                dur_q       <= (bus.cmd_duration == '0) ? DUR_ONE : bus.cmd_duration;
                elapsed_q   <= '0;
                timed_out_q <= 1'b0;
                aborted_q   <= 1'b0;
                for (int i = 0; i < NUM_PORTS; i++) frame_cnt_q[i] <= '0;
            end else begin
                // The abort cycle itself is not counted as run time.
                if (state_q == S_RUN && !bus.cmd_abort && elapsed_q != DUR_MAX)
                    elapsed_q <= elapsed_q + DUR_ONE;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (counting && bus.tx_last_fire[i] && mask_q[i] && frame_cnt_q[i] != CNT_MAX)
                        frame_cnt_q[i] <= frame_cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    assign bus.gen_rst   = rst | (state_q == S_GEN_RST);
    assign bus.gen_start = (state_q == S_START) ? mask_q : '0;
    assign bus.gen_stop  = (state_q == S_STOP)  ? mask_q : '0;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.cmd_err   = cmd_err_q;
    assign bus.timed_out = timed_out_q;
    assign bus.aborted   = aborted_q;
    assign bus.elapsed   = elapsed_q;
    assign bus.dbg_state = state_q;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fc
        assign bus.frame_count[g*CNT_WIDTH +: CNT_WIDTH] = frame_cnt_q[g];
    end
endmodule

// File: tb/tb_tester_run_sequencer.sv
// Directed bench for tester_run_sequencer: whole runs, frame counting, timeout, abort,
// rejected commands and reset in the middle of a run.
module tb_tester_run_sequencer;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int CW = 32;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   n;
    logic [CW-1:0] exp_q[$];

    tester_run_sequencer_if #(.NUM_PORTS(NP), .DUR_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    tester_run_sequencer #(
        .NUM_PORTS(NP), .DUR_WIDTH(DW), .CNT_WIDTH(CW),
        .GEN_RST_CYCLES(4), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stops the run if it ever stalls.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return bus.done;
            1:       return |bus.gen_start;
            2:       return |bus.gen_stop;
            default: return 1'b0;
        endcase
    endfunction

    // Ticks until the selected event is visible, within a cycle budget.
    task automatic wait_for(input int which, input int max_cyc, input string tag, output int cyc);
        cyc = 0;
        while (!sel(which) && cyc < max_cyc) begin
            tick();
            cyc++;
        end
        check(tag, {63'd0, sel(which)}, 64'd1);
    endtask

    function automatic logic [CW-1:0] fc(input int p);
        return bus.frame_count[p*CW +: CW];
    endfunction

    task automatic start_run(input logic [NP-1:0] mask, input logic [DW-1:0] dur);
        bus.cmd_port_mask = mask;
        bus.cmd_duration  = dur;
        bus.cmd_start     = 1'b1;
        tick();
        bus.cmd_start     = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.cmd_start = 1'b0;
        bus.cmd_abort = 1'b0;
        bus.cmd_port_mask = '0;
        bus.cmd_duration = '0;
        bus.gen_ready = 4'hF;
        bus.tx_last_fire = '0;
        repeat (3) tick();

        // Reset state.
        check("rst_gen_rst", bus.gen_rst, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_gen_start", bus.gen_start, 0);
        check("rst_elapsed", bus.elapsed, 0);
        check("rst_frame_count", bus.frame_count[63:0], 0);
        check("rst_status", {bus.timed_out, bus.aborted, bus.cmd_err}, 0);
        rst = 1'b0;
        tick();
        check("idle_gen_rst", bus.gen_rst, 0);

        // Basic run: mask 0101, duration 100, generators always ready.
        start_run(4'b0101, 100);
        check("t1_busy", bus.busy, 1);
        n = 0;
        while (bus.gen_rst && n < 20) begin
            n++;
            tick();
        end
        check("t1_gen_rst_cycles", n, 4);
        check("t1_no_start_wait", bus.gen_start, 0);
        tick();
        check("t1_gen_start", bus.gen_start, 4'b0101);
        tick();
        check("t1_start_one_cycle", bus.gen_start, 0);
        wait_for(2, 200, "t1_stop_seen", n);
        check("t1_run_cycles", n, 100);
        check("t1_gen_stop", bus.gen_stop, 4'b0101);
        check("t1_elapsed", bus.elapsed, 100);
        wait_for(0, 50, "t1_done_seen", n);
        check("t1_status", {bus.timed_out, bus.aborted}, 0);
        tick();
        check("t1_idle", {bus.busy, bus.done}, 0);

        // Frame counting, only masked ports count.
        start_run(4'b0001, 50);
        wait_for(1, 20, "t2_start_seen", n);
        tick();
        for (int i = 0; i < 7; i++) begin
            bus.tx_last_fire = (i < 3) ? 4'b0011 : 4'b0001;
            tick();
            bus.tx_last_fire = '0;
            tick();
        end
        wait_for(2, 100, "t2_stop_seen", n);
        wait_for(0, 50, "t2_done_seen", n);
        exp_q.push_back(7);
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        for (int p = 0; p < NP; p++) begin
            check($sformatf("t2_frame_count%0d", p), fc(p), exp_q.pop_front());
        end
        tick();

        // Drain timeout: port 2 never returns to ready.
        start_run(4'b0100, 5);
        wait_for(2, 30, "t3_stop_seen", n);
        check("t3_gen_stop", bus.gen_stop, 4'b0100);
        bus.gen_ready = 4'b1011;
        wait_for(0, 1100, "t3_done_seen", n);
        check("t3_drain_cycles", n, 1025);
        check("t3_timed_out", bus.timed_out, 1);
        check("t3_not_aborted", bus.aborted, 0);
        tick();
        check("t3_timed_out_held", bus.timed_out, 1);
        bus.gen_ready = 4'hF;

        // Abort at RUN cycle 10; a start while busy is ignored.
        start_run(4'b0001, 1000);
        check("t4_timed_out_cleared", bus.timed_out, 0);
        wait_for(1, 20, "t4_start_seen", n);
        tick();
        bus.cmd_port_mask = 4'hF;
        bus.cmd_duration = 7;
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        check("t4_busy_ignore", {bus.busy, bus.gen_start}, 5'b10000);
        repeat (9) tick();
        check("t4_elapsed_pre", bus.elapsed, 10);
        bus.cmd_abort = 1'b1;
        tick();
        bus.cmd_abort = 1'b0;
        check("t4_gen_stop", bus.gen_stop, 4'b0001);
        check("t4_aborted", bus.aborted, 1);
        check("t4_elapsed", bus.elapsed, 10);
        wait_for(0, 50, "t4_done_seen", n);
        check("t4_elapsed_done", bus.elapsed, 10);
        tick();

        // Start with an empty mask.
        bus.cmd_port_mask = '0;
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        check("t5_cmd_err", bus.cmd_err, 1);
        check("t5_busy", bus.busy, 0);
        check("t5_aborted_held", bus.aborted, 1);
        tick();
        check("t5_cmd_err_pulse", bus.cmd_err, 0);

        // Abort while waiting for ready.
        bus.gen_ready = 4'b0000;
        start_run(4'b0010, 20);
        repeat (4) tick();
        check("t6_wait_rdy", {bus.busy, bus.gen_rst}, 2'b10);
        bus.cmd_abort = 1'b1;
        tick();
        bus.cmd_abort = 1'b0;
        check("t6_done", bus.done, 1);
        check("t6_aborted", bus.aborted, 1);
        check("t6_no_start", bus.gen_start, 0);
        tick();
        bus.gen_ready = 4'hF;

        // Duration 0 runs for one cycle.
        start_run(4'b0001, 0);
        check("t7_aborted_cleared", bus.aborted, 0);
        wait_for(1, 20, "t7_start_seen", n);
        tick();
        wait_for(2, 20, "t7_stop_seen", n);
        check("t7_run_cycles", n, 1);
        check("t7_elapsed", bus.elapsed, 1);
        wait_for(0, 50, "t7_done_seen", n);
        tick();

        // Reset in the middle of a run.
        start_run(4'b0011, 200);
        wait_for(1, 20, "t8_start_seen", n);
        tick();
        bus.tx_last_fire = 4'b0011;
        tick();
        bus.tx_last_fire = '0;
        check("t8_frame_count0", fc(0), 1);
        check("t8_frame_count1", fc(1), 1);
        rst = 1'b1;
        tick();
        check("t8_busy", bus.busy, 0);
        check("t8_gen_rst", bus.gen_rst, 1);
        check("t8_frame_count0_clr", fc(0), 0);
        check("t8_elapsed_clr", bus.elapsed, 0);
        check("t8_no_done", bus.done, 0);
        rst = 1'b0;
        tick();
        check("t8_after_rst", {bus.done, bus.busy, bus.gen_rst}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
